// File: rtl/exp_horner_if.sv
// ============================================================================
// Module      : exp_horner_if
// Description : Request/response bundle for the ApproxExp Horner loop stage.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface exp_horner_if;
  logic        start;
  logic [62:0] z_63;
  logic [62:0] ccs_63;
  logic [5:0]  s_in;
  logic        busy;
  logic        done;
  logic [63:0] y_64;
  logic [5:0]  s_out;

  modport master (
    output start, z_63, ccs_63, s_in,
    input  busy, done, y_64, s_out
  );

  modport slave (
    input  start, z_63, ccs_63, s_in,
    output busy, done, y_64, s_out
  );
endinterface

`default_nettype wire

// File: rtl/exp_horner_loop.sv
// ============================================================================
// Module      : exp_horner_loop
// Description : Iterative fixed-point exp(-r) Horner evaluation scaled by ccs,
//               sharing one 64x64 multiplier across all iterations.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module exp_horner_loop #(
  parameter int N_COEF = 13
) (
  input  logic          clk,
  input  logic          rst_n,
  exp_horner_if.slave   bus
);

  localparam int IDX_W = $clog2(N_COEF);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_COEF - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_MUL   = 3'd1,
    S_SUB   = 3'd2,
    S_SCALE = 3'd3,
    S_FIN   = 3'd4
  } state_t;

  state_t             state_q, state_d;
  logic [63:0]        z_q, z_d;
  logic [63:0]        c_q, c_d;
  logic [63:0]        y_q, y_d;
  logic [127:0]       prod_q, prod_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [63:0]        y_out_q, y_out_d;
  logic [5:0]         s_q, s_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  logic [63:0]        w_mul_a;
  logic [127:0]       w_prod;

  function automatic logic [63:0] coef(input logic [IDX_W-1:0] i);
    case (int'(i))
      0:       coef = 64'h00000004741183A3;
      1:       coef = 64'h00000036548CFC06;
      2:       coef = 64'h0000024FDCBF140A;
      3:       coef = 64'h0000171D939DE045;
      4:       coef = 64'h0000D00CF58F6F84;
      5:       coef = 64'h000680681CF796E3;
      6:       coef = 64'h002D82D8305B0FEA;
      7:       coef = 64'h011111110E066FD0;
      8:       coef = 64'h0555555555070F00;
      9:       coef = 64'h155555555581FF00;
      10:      coef = 64'h400000000002B400;
      11:      coef = 64'h7FFFFFFFFFFF4800;
      12:      coef = 64'h8000000000000000;
      default: coef = 64'h0000000000000000;
    endcase
  endfunction

  // The single multiplier sees r during the loop and ccs during the final scale.
  assign w_mul_a = (state_q == S_SCALE) ? c_q : z_q;
  assign w_prod  = {64'd0, w_mul_a} * {64'd0, y_q};

  always_comb begin
    state_d = state_q;
    z_d     = z_q;
    c_d     = c_q;
    y_d     = y_q;
    prod_d  = prod_q;
    idx_d   = idx_q;
    y_out_d = y_out_q;
    s_d     = s_q;
    busy_d  = busy_q;
    done_d  = 1'b0;

    case (state_q)
      S_IDLE: begin
        busy_d = 1'b0;
        if (bus.start) begin
          state_d = S_MUL;
          busy_d  = 1'b1;
          z_d     = {bus.z_63, 1'b0};
          c_d     = {bus.ccs_63, 1'b0};
          y_d     = coef('0);
          idx_d   = IDX_W'(1);
          s_d     = bus.s_in;
        end
      end
      S_MUL: begin
        prod_d  = w_prod;
        state_d = S_SUB;
      end
      S_SUB: begin
        y_d     = coef(idx_q) - prod_q[127:64];
        idx_d   = idx_q + 1'b1;
        state_d = (idx_q == IDX_LAST) ? S_SCALE : S_MUL;
      end
      S_SCALE: begin
        prod_d  = w_prod;
        state_d = S_FIN;
      end
      S_FIN: begin
        // busy stays high through the done cycle; IDLE drops it afterwards.
        y_out_d = prod_q[127:64];
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      z_q     <= '0;
      c_q     <= '0;
      y_q     <= '0;
      prod_q  <= '0;
      idx_q   <= '0;
      y_out_q <= '0;
      s_q     <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      z_q     <= z_d;
      c_q     <= c_d;
      y_q     <= y_d;
      prod_q  <= prod_d;
      idx_q   <= idx_d;
      y_out_q <= y_out_d;
      s_q     <= s_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign bus.busy  = busy_q;
  assign bus.done  = done_q;
  assign bus.y_64  = y_out_q;
  assign bus.s_out = s_q;

endmodule

`default_nettype wire

// File: tb/tb_exp_horner_loop.sv
// ============================================================================
// Module      : tb_exp_horner_loop
// Description : Self-checking bench for exp_horner_loop against a cycle-level
//               behavioural reference.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_exp_horner_loop;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;
  int   cyc;

  exp_horner_if bus ();

  exp_horner_loop #(.N_COEF(13)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  localparam logic [62:0] LN2_63  = 63'h58B90BFBE8E7BCD5;
  localparam logic [62:0] CCS_MAX = 63'h7FFFFFFFFFFFFFFF;
  localparam logic [62:0] CCS_HALF = 63'h4000000000000000;

  logic [63:0] coef_tab [13];
  initial begin
    coef_tab[0]  = 64'h00000004741183A3;
    coef_tab[1]  = 64'h00000036548CFC06;
    coef_tab[2]  = 64'h0000024FDCBF140A;
    coef_tab[3]  = 64'h0000171D939DE045;
    coef_tab[4]  = 64'h0000D00CF58F6F84;
    coef_tab[5]  = 64'h000680681CF796E3;
    coef_tab[6]  = 64'h002D82D8305B0FEA;
    coef_tab[7]  = 64'h011111110E066FD0;
    coef_tab[8]  = 64'h0555555555070F00;
    coef_tab[9]  = 64'h155555555581FF00;
    coef_tab[10] = 64'h400000000002B400;
    coef_tab[11] = 64'h7FFFFFFFFFFF4800;
    coef_tab[12] = 64'h8000000000000000;
  end

  // Plain-arithmetic ApproxExp reference: Horner loop then ccs scaling.
  function automatic logic [63:0] ref_exp(input logic [62:0] z63, input logic [62:0] c63);
    logic [127:0] z, c, y, p;
    z = {65'd0, z63, 1'b0};
    c = {65'd0, c63, 1'b0};
    y = {64'd0, coef_tab[0]};
    for (int i = 1; i < 13; i++) begin
      p = z * y;
      y = {64'd0, coef_tab[i] - p[127:64]};
    end
    p = c * y;
    return p[127:64];
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference timing: 26 edges from accept to done, done cycle still busy.
  int          m_cnt;
  logic        m_done;
  logic [63:0] m_y, m_pend;
  logic [5:0]  m_s;

  initial begin : compare_proc
    m_cnt = 0; m_done = 1'b0; m_y = '0; m_pend = '0; m_s = '0;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        m_cnt = 0; m_done = 1'b0; m_y = '0; m_s = '0;
      end else begin
        m_done = 1'b0;
        if (m_cnt > 0) begin
          m_cnt--;
          if (m_cnt == 0) begin
            m_done = 1'b1;
            m_y    = m_pend;
          end
        end else if (bus.start) begin
          m_cnt  = 26;
          m_pend = ref_exp(bus.z_63, bus.ccs_63);
          m_s    = bus.s_in;
        end
        #1;
        chk("busy",  64'(bus.busy),  64'((m_cnt > 0) || m_done));
        chk("done",  64'(bus.done),  64'(m_done));
        chk("y_64",  bus.y_64,       m_y);
        chk("s_out", 64'(bus.s_out), 64'(m_s));
      end
    end
  end

  task automatic issue(input logic [62:0] z, input logic [62:0] c, input logic [5:0] s,
                       output int at_cyc);
    at_cyc      = cyc;
    bus.start   = 1'b1;
    bus.z_63    = z;
    bus.ccs_63  = c;
    bus.s_in    = s;
    @(negedge clk);
    bus.start   = 1'b0;
  endtask

  task automatic wait_done(input string name, output int at_cyc);
    bit seen;
    seen   = 1'b0;
    at_cyc = -1;
    for (int i = 0; i < 40; i++) begin
      if (bus.done) begin
        seen   = 1'b1;
        at_cyc = cyc;
        break;
      end
      @(negedge clk);
    end
    if (!seen) begin
      total++;
      bad++;
      $display("FAIL %s: done timeout, got none, expected within 40 cycles", name);
    end
  endtask

  int c0, d0, d1, ndone;
  logic [62:0] zr, cr;
  logic [5:0]  sr;
  logic [63:0] diff;

  initial begin
    total = 0; bad = 0; cyc = 0;
    rst_n = 1'b0;
    bus.start = 1'b0; bus.z_63 = '0; bus.ccs_63 = '0; bus.s_in = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy",  64'(bus.busy),  64'd0);
    chk("rst_done",  64'(bus.done),  64'd0);
    chk("rst_y",     bus.y_64,       64'd0);
    chk("rst_s",     64'(bus.s_out), 64'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // T1: zero scale, latency check
    issue(63'd0, 63'd0, 6'd5, c0);
    wait_done("t1", d0);
    chk("t1_latency", 64'(d0 - c0), 64'd27);
    chk("t1_y", bus.y_64, 64'd0);
    chk("t1_s", 64'(bus.s_out), 64'd5);
    repeat (3) @(negedge clk);

    // T2: r=0, ccs max
    issue(63'd0, CCS_MAX, 6'd17, c0);
    wait_done("t2", d0);
    chk("t2_y", bus.y_64, 64'h7FFFFFFFFFFFFFFF);
    chk("t2_s", 64'(bus.s_out), 64'd17);
    repeat (2) @(negedge clk);

    // r=0, ccs=0.5 -> exactly 2^62
    issue(63'd0, CCS_HALF, 6'd63, c0);
    wait_done("half", d0);
    chk("half_y", bus.y_64, 64'h4000000000000000);
    repeat (2) @(negedge clk);

    // T3: r=ln2, ccs max -> about 0.5
    issue(LN2_63, CCS_MAX, 6'd1, c0);
    wait_done("t3", d0);
    diff = (bus.y_64 > 64'h4000000000000000) ? bus.y_64 - 64'h4000000000000000
                                            : 64'h4000000000000000 - bus.y_64;
    chk("t3_near_half", 64'(diff < 64'h0000000100000000), 64'd1);
    chk("t3_y", bus.y_64, ref_exp(LN2_63, CCS_MAX));
    repeat (2) @(negedge clk);

    // T4: start pulses while busy are ignored
    issue(63'd0, CCS_MAX, 6'd9, c0);
    repeat (2) @(negedge clk);
    issue(LN2_63, 63'd0, 6'd1, d1);
    repeat (16) @(negedge clk);
    issue(LN2_63, 63'd0, 6'd2, d1);
    wait_done("t4", d0);
    chk("t4_latency", 64'(d0 - c0), 64'd27);
    chk("t4_y", bus.y_64, 64'h7FFFFFFFFFFFFFFF);
    chk("t4_s", 64'(bus.s_out), 64'd9);
    ndone = 0;
    repeat (30) begin
      @(negedge clk);
      if (bus.done) ndone++;
    end
    chk("t4_extra_done", 64'(ndone), 64'd0);

    // T5: reset at cycle 10 of an evaluation
    issue(LN2_63, CCS_HALF, 6'd44, c0);
    repeat (9) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("t5_busy", 64'(bus.busy),  64'd0);
    chk("t5_done", 64'(bus.done),  64'd0);
    chk("t5_y",    bus.y_64,       64'd0);
    chk("t5_s",    64'(bus.s_out), 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    ndone = 0;
    repeat (30) begin
      @(negedge clk);
      if (bus.done) ndone++;
    end
    chk("t5_no_done", 64'(ndone), 64'd0);
    issue(63'd0, CCS_HALF, 6'd3, c0);
    wait_done("t5_after", d0);
    chk("t5_after_y", bus.y_64, 64'h4000000000000000);
    chk("t5_after_s", 64'(bus.s_out), 64'd3);

    // T6: back-to-back random requests, start in each done cycle
    for (int n = 0; n < 1000; n++) begin
      zr = 63'({$urandom, $urandom} % {1'b0, LN2_63});
      cr = 63'({$urandom, $urandom});
      sr = 6'($urandom);
      issue(zr, cr, sr, c0);
      wait_done("t6", d1);
      if (n > 0) chk("t6_spacing", 64'(d1 - d0), 64'd27);
      chk("t6_y", bus.y_64, ref_exp(zr, cr));
      chk("t6_s", 64'(bus.s_out), 64'(sr));
      d0 = d1;
    end
    repeat (3) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
